// File: rtl/min_pkg.sv
// Shared types and helpers for the first-arrival (temporal min) arbiter.
//   state_t    : arbiter FSM states
//   TIE_*      : tie-resolution modes
//   lowest_set : lowest set bit of a vector as one-hot plus index
package min_pkg;

    // Widest input vector the helper supports; callers zero-extend into it.
    localparam int unsigned MAX_N     = 32;
    localparam int unsigned MAX_IDX_W = 5;

    localparam int unsigned TIE_LOWEST = 0;
    localparam int unsigned TIE_ALL    = 1;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        LOCKED = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_N-1:0]     onehot;
        logic [MAX_IDX_W-1:0] idx;
    } lsb_t;

    // Lowest set bit; all-zero input yields onehot=0, idx=0.
    function automatic lsb_t lowest_set(input logic [MAX_N-1:0] v);
        lsb_t             r;
        logic [MAX_N-1:0] probe;
        r.onehot = '0;
        r.idx    = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            probe = MAX_N'(1) << i;
            if ((r.onehot == '0) && ((v & probe) != '0)) begin
                r.onehot = probe;
                r.idx    = MAX_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gamma_timer.sv
// Gamma-cycle counter shared by race-logic blocks.
//   aclk, grst_n : clock, async active-low reset
//   gamma_start  : one-cycle strobe forcing the count back to 0
//   gcnt         : current position within the gamma cycle
//   boundary_c   : high when the coming edge puts gcnt at 0 (wrap or strobe)
module gamma_timer
    import min_pkg::*;
#(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16
) (
    input  logic                                 aclk,
    input  logic                                 grst_n,
    input  logic                                 gamma_start,
    output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] gcnt,
    output logic                                 boundary_c
);

    localparam int unsigned GW = $clog2(GAMMA_CYCLE_WIDTH);

    logic [GW-1:0] gcnt_q;
    logic [GW-1:0] gcnt_d;

    // Wrap at the last count, or restart on the strobe.
    always_comb begin
        boundary_c = gamma_start || (gcnt_q == GW'(GAMMA_CYCLE_WIDTH - 1));
        gcnt_d     = boundary_c ? '0 : gcnt_q + GW'(1);
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign gcnt = gcnt_q;

endmodule

// File: rtl/min_n_arb.sv
// N-input first-arrival arbiter for pulse-width-encoded race-logic spikes.
// The first rising edge in a gamma cycle wins; its pulse is forwarded on y
// (width preserved, capped at PULSE_WIDTH) and later arrivals are ignored
// until the next gamma boundary.
//   aclk, grst_n : clock, async active-low reset
//   gamma_start  : forces a new gamma cycle
//   in           : spike lines
//   y            : forwarded winner pulse
//   win_valid    : a winner is latched in this gamma cycle
//   win_onehot   : selected channel(s)
//   win_idx      : lowest selected index
//   win_time     : gamma count at which the winner arrived
//   pulse_err    : winner pulse hit the width cap (cleared at boundary)
module min_n_arb
    import min_pkg::*;
#(
    parameter int unsigned N_INPUTS          = 4,
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter int unsigned TIE_MODE          = 0
) (
    input  logic                                 aclk,
    input  logic                                 grst_n,
    input  logic                                 gamma_start,
    input  logic [N_INPUTS-1:0]                  in,
    output logic                                 y,
    output logic                                 win_valid,
    output logic [N_INPUTS-1:0]                  win_onehot,
    output logic [$clog2(N_INPUTS)-1:0]          win_idx,
    output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] win_time,
    output logic                                 pulse_err
);

    localparam int unsigned IDX_W = $clog2(N_INPUTS);
    localparam int unsigned TW    = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int unsigned PW    = $clog2(PULSE_WIDTH + 1);

    logic [TW-1:0]       gcnt;
    logic                boundary_c;

    state_t              state_q,      state_d;
    logic [N_INPUTS-1:0] prev_in_q,    prev_in_d;
    logic [PW-1:0]       plen_q,       plen_d;
    logic                y_q,          y_d;
    logic                win_valid_q,  win_valid_d;
    logic [N_INPUTS-1:0] win_onehot_q, win_onehot_d;
    logic [IDX_W-1:0]    win_idx_q,    win_idx_d;
    logic [TW-1:0]       win_time_q,   win_time_d;
    logic                pulse_err_q,  pulse_err_d;

    state_t              cur_state_c;
    logic [N_INPUTS-1:0] rise_c;
    logic [N_INPUTS-1:0] sel_c;
    lsb_t                lsb_c;
    logic                unused_lsb_c;

    gamma_timer #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH)
    ) u_gamma_timer (
        .aclk        (aclk),
        .grst_n      (grst_n),
        .gamma_start (gamma_start),
        .gcnt        (gcnt),
        .boundary_c  (boundary_c)
    );

    // Arrival detection and tie resolution.
    always_comb begin
        rise_c = in & ~prev_in_q;
        lsb_c  = lowest_set(MAX_N'(rise_c));
        sel_c  = (TIE_MODE == TIE_ALL) ? rise_c : lsb_c.onehot[N_INPUTS-1:0];
    end

    // Upper helper bits beyond N_INPUTS / IDX_W are intentionally dropped.
    assign unused_lsb_c = ^lsb_c;

    // Next-state and output logic. A boundary re-arms first so that an
    // arrival on the boundary edge is evaluated as a fresh-cycle arrival.
    always_comb begin
        state_d      = state_q;
        prev_in_d    = in;
        plen_d       = plen_q;
        y_d          = y_q;
        win_valid_d  = win_valid_q;
        win_onehot_d = win_onehot_q;
        win_idx_d    = win_idx_q;
        win_time_d   = win_time_q;
        pulse_err_d  = pulse_err_q;
        cur_state_c  = state_q;

        if (boundary_c) begin
            cur_state_c  = ARMED;
            state_d      = ARMED;
            y_d          = 1'b0;
            win_valid_d  = 1'b0;
            win_onehot_d = '0;
            pulse_err_d  = 1'b0;
        end

        case (cur_state_c)
            ARMED: begin
                if (|rise_c) begin
                    win_onehot_d = sel_c;
                    win_idx_d    = IDX_W'(lsb_c.idx);
                    win_time_d   = boundary_c ? '0 : gcnt;
                    win_valid_d  = 1'b1;
                    y_d          = 1'b1;
                    plen_d       = PW'(1);
                    state_d      = LOCKED;
                end
            end
            LOCKED: begin
                if (!(|(in & win_onehot_q))) begin
                    y_d     = 1'b0;
                    state_d = DONE;
                end else if (plen_q == PW'(PULSE_WIDTH)) begin
                    y_d         = 1'b0;
                    pulse_err_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    y_d    = 1'b1;
                    plen_d = plen_q + PW'(1);
                end
            end
            DONE: begin
                y_d = 1'b0;
            end
            default: begin
                y_d     = 1'b0;
                state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q      <= ARMED;
            prev_in_q    <= '0;
            plen_q       <= '0;
            y_q          <= 1'b0;
            win_valid_q  <= 1'b0;
            win_onehot_q <= '0;
            win_idx_q    <= '0;
            win_time_q   <= '0;
            pulse_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_in_q    <= prev_in_d;
            plen_q       <= plen_d;
            y_q          <= y_d;
            win_valid_q  <= win_valid_d;
            win_onehot_q <= win_onehot_d;
            win_idx_q    <= win_idx_d;
            win_time_q   <= win_time_d;
            pulse_err_q  <= pulse_err_d;
        end
    end

    assign y          = y_q;
    assign win_valid  = win_valid_q;
    assign win_onehot = win_onehot_q;
    assign win_idx    = win_idx_q;
    assign win_time   = win_time_q;
    assign pulse_err  = pulse_err_q;

endmodule

// File: tb/tb_min_n_arb.sv
// Directed bench for min_n_arb: two instances (lowest-index and all-tied
// modes) share the stimulus. Inputs change and outputs are sampled on the
// falling edge; g tracks the gamma count the DUT holds in the current cycle.
module tb_min_n_arb;

    logic       aclk;
    logic       grst_n;
    logic       gamma_start;
    logic [3:0] in_v;

    logic       y0, wv0, pe0, y1, wv1, pe1;
    logic [3:0] oh0, oh1;
    logic [1:0] idx0, idx1;
    logic [3:0] wt0, wt1;

    int n_chk;
    int n_pass;
    int g;

    min_n_arb #(.N_INPUTS(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TIE_MODE(0)) dut0 (
        .aclk(aclk), .grst_n(grst_n), .gamma_start(gamma_start), .in(in_v),
        .y(y0), .win_valid(wv0), .win_onehot(oh0), .win_idx(idx0),
        .win_time(wt0), .pulse_err(pe0)
    );

    min_n_arb #(.N_INPUTS(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TIE_MODE(1)) dut1 (
        .aclk(aclk), .grst_n(grst_n), .gamma_start(gamma_start), .in(in_v),
        .y(y1), .win_valid(wv1), .win_onehot(oh1), .win_idx(idx1),
        .win_time(wt1), .pulse_err(pe1)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: returns at the following falling edge with g updated.
    task automatic step();
        logic gs;
        @(posedge aclk);
        gs = gamma_start;
        @(negedge aclk);
        g = gs ? 0 : ((g == 15) ? 0 : g + 1);
    endtask

    task automatic vec(input string tag, input logic [3:0] iv, input logic gs,
                       input logic ey0, input logic ey1);
        in_v        = iv;
        gamma_start = gs;
        step();
        gamma_start = 1'b0;
        check_eq({tag, "_y0"}, 32'(y0), 32'(ey0));
        check_eq({tag, "_y1"}, 32'(y1), 32'(ey1));
    endtask

    task automatic idle_to(input int target);
        for (int k = 0; k < 40; k++) begin
            if (g == target) break;
            step();
        end
    endtask

    task automatic new_gamma();
        in_v        = 4'b0000;
        gamma_start = 1'b1;
        step();
        gamma_start = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ycnt;
        n_chk = 0; n_pass = 0; g = 0;
        grst_n = 1'b0; gamma_start = 1'b0; in_v = 4'b0000;

        // Reset state
        repeat (2) @(negedge aclk);
        check_eq("rst_y0",   32'(y0),   32'd0);
        check_eq("rst_wv0",  32'(wv0),  32'd0);
        check_eq("rst_oh0",  32'(oh0),  32'd0);
        check_eq("rst_idx0", 32'(idx0), 32'd0);
        check_eq("rst_wt0",  32'(wt0),  32'd0);
        check_eq("rst_pe0",  32'(pe0),  32'd0);
        check_eq("rst_y1",   32'(y1),   32'd0);
        grst_n = 1'b1;
        g = 0;

        // 1. Basic win: in[2] at 5..7, late in[0] at 7..9 ignored
        new_gamma();
        idle_to(5);
        vec("t1_g5", 4'b0100, 1'b0, 1'b1, 1'b1);
        check_eq("t1_oh0",  32'(oh0),  32'h4);
        check_eq("t1_idx0", 32'(idx0), 32'd2);
        check_eq("t1_wt0",  32'(wt0),  32'd5);
        check_eq("t1_wv0",  32'(wv0),  32'd1);
        vec("t1_g6",  4'b0100, 1'b0, 1'b1, 1'b1);
        vec("t1_g7",  4'b0101, 1'b0, 1'b1, 1'b1);
        vec("t1_g8",  4'b0001, 1'b0, 1'b0, 1'b0);
        vec("t1_g9",  4'b0001, 1'b0, 1'b0, 1'b0);
        vec("t1_g10", 4'b0000, 1'b0, 1'b0, 1'b0);
        check_eq("t1_idx0_hold", 32'(idx0), 32'd2);
        check_eq("t1_oh0_hold",  32'(oh0),  32'h4);

        // 2. Tie: in[1] width 2, in[3] width 5, both rise at 4
        new_gamma();
        idle_to(4);
        vec("t2_g4", 4'b1010, 1'b0, 1'b1, 1'b1);
        check_eq("t2_oh0",  32'(oh0),  32'h2);
        check_eq("t2_oh1",  32'(oh1),  32'ha);
        check_eq("t2_idx0", 32'(idx0), 32'd1);
        check_eq("t2_idx1", 32'(idx1), 32'd1);
        check_eq("t2_wt1",  32'(wt1),  32'd4);
        vec("t2_g5", 4'b1010, 1'b0, 1'b1, 1'b1);
        vec("t2_g6", 4'b1000, 1'b0, 1'b0, 1'b1);
        vec("t2_g7", 4'b1000, 1'b0, 1'b0, 1'b1);
        vec("t2_g8", 4'b1000, 1'b0, 1'b0, 1'b1);
        vec("t2_g9", 4'b0000, 1'b0, 1'b0, 1'b0);

        // 3. Overlong: in[0] high for gcnt 2..13, capped at 8 cycles
        new_gamma();
        idle_to(2);
        ycnt = 0;
        for (int k = 2; k < 16; k++) begin
            vec($sformatf("t3_g%0d", k), (k <= 13) ? 4'b0001 : 4'b0000, 1'b0,
                k <= 9, k <= 9);
            if (y0) ycnt++;
            check_eq($sformatf("t3_pe0_g%0d", k), 32'(pe0),
                     32'((k >= 10) && (k < 15)));
        end
        check_eq("t3_width", 32'(ycnt), 32'd8);
        check_eq("t3_wv0_after_wrap", 32'(wv0), 32'd0);

        // 4. Wrap without gamma_start: in[1] held across wrap
        idle_to(12);
        vec("t4_g12", 4'b0010, 1'b0, 1'b1, 1'b1);
        vec("t4_g13", 4'b0010, 1'b0, 1'b1, 1'b1);
        vec("t4_g14", 4'b0010, 1'b0, 1'b1, 1'b1);
        vec("t4_g15", 4'b0010, 1'b0, 1'b0, 1'b0);
        check_eq("t4_wv0_wrap",  32'(wv0),  32'd0);
        check_eq("t4_oh0_wrap",  32'(oh0),  32'd0);
        check_eq("t4_idx0_hold", 32'(idx0), 32'd1);
        check_eq("t4_wt0_hold",  32'(wt0),  32'd12);
        vec("t4_g0", 4'b0010, 1'b0, 1'b0, 1'b0);
        vec("t4_g1", 4'b0010, 1'b0, 1'b0, 1'b0);
        vec("t4_g2", 4'b0010, 1'b0, 1'b0, 1'b0);
        check_eq("t4_wv0_pre", 32'(wv0), 32'd0);
        vec("t4_g3", 4'b0110, 1'b0, 1'b1, 1'b1);
        check_eq("t4_idx0", 32'(idx0), 32'd2);
        check_eq("t4_wt0",  32'(wt0),  32'd3);
        check_eq("t4_oh0",  32'(oh0),  32'h4);
        check_eq("t4_wv0",  32'(wv0),  32'd1);
        vec("t4_g4", 4'b0110, 1'b0, 1'b1, 1'b1);
        vec("t4_g5", 4'b0010, 1'b0, 1'b0, 1'b0);

        // 5. Boundary collision: gamma_start on the in[3] rise edge
        vec("t5_edge", 4'b1000, 1'b1, 1'b1, 1'b1);
        check_eq("t5_idx0", 32'(idx0), 32'd3);
        check_eq("t5_wt0",  32'(wt0),  32'd0);
        check_eq("t5_wv0",  32'(wv0),  32'd1);

        // 6. Async reset while y is high
        vec("t6_pre", 4'b1000, 1'b0, 1'b1, 1'b1);
        #2 grst_n = 1'b0;
        #1;
        check_eq("t6_y0",   32'(y0),   32'd0);
        check_eq("t6_wv0",  32'(wv0),  32'd0);
        check_eq("t6_oh0",  32'(oh0),  32'd0);
        check_eq("t6_idx0", 32'(idx0), 32'd0);
        check_eq("t6_wt0",  32'(wt0),  32'd0);
        check_eq("t6_pe0",  32'(pe0),  32'd0);
        check_eq("t6_y1",   32'(y1),   32'd0);
        in_v = 4'b0000;
        @(negedge aclk);
        check_eq("t6_y0_held", 32'(y0), 32'd0);
        grst_n = 1'b1;
        g = 0;
        vec("t6_g0", 4'b0000, 1'b0, 1'b0, 1'b0);
        vec("t6_g1", 4'b0001, 1'b0, 1'b1, 1'b1);
        check_eq("t6_oh0_win", 32'(oh0), 32'h1);
        check_eq("t6_wt0_win", 32'(wt0), 32'd1);
        check_eq("t6_wv0_win", 32'(wv0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
